pc_sequencer: RTL
=================

# pc_sequencer

Control block that sequences the program counter register. Each cycle it decides whether the PC register loads and which value it loads: reset vector, exception vector, jump target, branch target or sequential increment. It handshakes with instruction fetch, honours pipeline stalls and halt/resume, and buffers one redirect that arrives while the PC cannot advance. It drives the PC register's `datain` and `enable` directly and reads back its `dataout`.

## Interface
- `WIDTH`, 32, address width.
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.
- `EXC_VECTOR`, 32'h0000_0080, exception handler address.
- `INC`, 4, sequential increment in bytes.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low = reset.
- `pc_cur`  in  WIDTH  current PC, from PC register `dataout`.
- `fetch_req`  out  1  instruction fetch request at `pc_cur`.
- `fetch_ack`  in  1  fetch completed this cycle.
- `stall`  in  1  pipeline cannot accept a new instruction.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  WIDTH  branch address.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  WIDTH  jump address.
- `exception`  in  1  redirect to `EXC_VECTOR`.
- `halt`  in  1  stop after the current fetch.
- `resume`  in  1  leave HALTED.
- `pc_next`  out  WIDTH  to PC register `datain`.
- `pc_enable`  out  1  to PC register `enable`.
- `redirect_pending`  out  1  pending redirect register valid.
- `state`  out  2  current FSM state, for debug.

## Operation
- States: BOOT=0, FETCH=1, HOLD=2, HALTED=3.
- Reset (`reset` low): `state`=BOOT, pending cleared, `fetch_req`=0, `redirect_pending`=0. `pc_enable` is forced to 0 while `reset` is low. `pc_next`=RESET_VECTOR.
- BOOT: `pc_enable`=1, `pc_next`=RESET_VECTOR. Goes to FETCH on the next cycle.
- FETCH: `fetch_req`=1.
  - `fetch_ack`=1, `stall`=0, `halt`=0: PC updates (`pc_enable`=1, `pc_next`=selected). Stays in FETCH.
  - `fetch_ack`=1, `stall`=1: no PC update. Goes to HOLD.
  - `fetch_ack`=1, `halt`=1, `stall`=0: no PC update. Goes to HALTED.
  - `fetch_ack`=1, `halt`=1, `stall`=1: goes to HOLD.
  - `fetch_ack`=0: wait in FETCH.
- HOLD: `fetch_req`=0.
  - When `stall`=0: PC updates and the block goes to FETCH, or to HALTED if `halt`=1 (no update in that case).
- HALTED: `fetch_req`=0, `pc_enable`=0.
  - `exception`, `jump` and `branch_taken` are ignored.
  - `resume`=1 goes to FETCH; `pending` is retained.
- Next-PC selection on an update cycle, highest priority first:
  1. `exception` → EXC_VECTOR.
  2. Pending → pending target.
  3. `jump` → `jump_target`.
  4. `branch_taken` → `branch_target`.
  5. Otherwise `pc_cur`+INC, modulo 2^WIDTH; the all-ones region wraps to 0.
- Pending register (valid bit plus target) is captured in any non-HALTED, non-BOOT cycle where a redirect input is high and the PC does not update:
  - `exception` always overwrites the pending register with EXC_VECTOR.
  - `jump` or `branch_taken` writes only if pending is empty; `jump` wins over `branch_taken`.
  - Cleared on every PC update cycle. If a redirect input is high in that same cycle, it is consumed by the selection, not latched.
- Reset mid-operation: returns to BOOT immediately; pending is lost; any fetch in flight is abandoned.

## Timing
- `pc_next` and `pc_enable` are combinational from state, the pending register and inputs. The PC register loads on the same rising edge on which `fetch_ack` is sampled. Latency from ack to new `pc_cur` is 1 edge.
- `fetch_req`, `state` and `redirect_pending` are registered.
- First `fetch_req` is asserted 1 cycle after `reset` rises. `pc_cur`=RESET_VECTOR in that cycle.
- Redirect held in pending takes effect on the next update, 1 edge after the stall clears or the ack arrives.
- `resume` reaches FETCH in 1 cycle. `halt` and `resume` asserted together in HALTED: `resume` wins.

## Structure
- Package `pc_seq_pkg`: state encodings (BOOT, FETCH, HOLD, HALTED) and default vector constants.
- Sub-module `pc_next_sel`: combinational priority mux plus incrementer. The FSM and pending register stay in `pc_sequencer`.

## Test plan
- **Boot:** hold `reset` low 3 cycles, then release.
  - During reset: `pc_enable`=0, `fetch_req`=0.
  - First cycle after release: `pc_enable`=1, `pc_next`=0.
  - Next cycle: `fetch_req`=1, `state`=1.
- **Sequential advance:** `pc_cur`=8, `fetch_ack`=1 → `pc_next`=12, `pc_enable`=1.
- **Wrap:** `pc_cur`=32'hFFFF_FFFC with ack → `pc_next`=0.
- **Stall with buffered branch:**
  - `pc_cur`=8, ack with `stall`=1 → HOLD, `pc_enable`=0.
  - `branch_taken`=1, `branch_target`=0x40 during HOLD → `redirect_pending`=1.
  - `stall` drops → `pc_next`=0x40, `pc_enable`=1, pending cleared.
- **Priority and override:**
  - Ack with `exception`, `jump` (0x100) and `branch_taken` (0x40) all high → `pc_next`=0x80.
  - While waiting (no ack): `jump` to 0x100, then `exception` → pending target=0x80. Next ack → `pc_next`=0x80.
- **Halt and reset:**
  - Ack with `halt`=1 → HALTED, no update. `exception` ignored; `resume`=1 → FETCH.
  - Drive `reset` low mid-HOLD with pending set → BOOT next, `redirect_pending`=0, `fetch_req`=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encodings and default vectors.
package pc_seq_pkg;

   localparam int unsigned DEF_WIDTH        = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
   localparam int unsigned DEF_INC          = 4;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception, pending redirect, jump, branch, then sequential increment.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int unsigned      WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
   parameter int unsigned      INC        = DEF_INC
) (
   input  logic [WIDTH-1:0] pc_cur,
   input  logic             exception,
   input  logic             pend_valid,
   input  logic [WIDTH-1:0] pend_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] pc_sel_c
);

   // Sequential path relies on natural modulo-2^WIDTH wrap of the adder.
   always_comb begin
      pc_sel_c = pc_cur + WIDTH'(INC);
      if (exception)         pc_sel_c = EXC_VECTOR;
      else if (pend_valid)   pc_sel_c = pend_target;
      else if (jump)         pc_sel_c = jump_target;
      else if (branch_taken) pc_sel_c = branch_target;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, stall/halt control and a one-entry redirect buffer.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
   parameter int unsigned      INC          = DEF_INC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_cur,
   output logic             fetch_req,
   input  logic             fetch_ack,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             exception,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc_next,
   output logic             pc_enable,
   output logic             redirect_pending,
   output logic [1:0]       state
);

   state_t           state_q, state_d;
   logic             pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0] pend_target_q, pend_target_d;
   logic             fetch_req_q;
   logic             upd;
   logic [WIDTH-1:0] pc_sel_c;

   pc_next_sel #(
      .WIDTH      (WIDTH),
      .EXC_VECTOR (EXC_VECTOR),
      .INC        (INC)
   ) u_sel (
      .pc_cur        (pc_cur),
      .exception     (exception),
      .pend_valid    (pend_valid_q),
      .pend_target   (pend_target_q),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_sel_c      (pc_sel_c)
   );

   // State, pending redirect and fetch request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_BOOT;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         fetch_req_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         fetch_req_q   <= (state_d == ST_FETCH);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:   state_d = ST_FETCH;
         ST_FETCH: begin
            if (fetch_ack) begin
               if (stall)     state_d = ST_HOLD;
               else if (halt) state_d = ST_HALTED;
            end
         end
         ST_HOLD: begin
            if (!stall) state_d = halt ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: begin
            if (resume) state_d = ST_FETCH;
         end
         default:   state_d = ST_BOOT;
      endcase
   end

   // Update decision, PC register drive and pending-redirect capture.
   always_comb begin
      upd           = 1'b0;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      case (state_q)
         ST_BOOT:  upd = 1'b1;
         ST_FETCH: upd = fetch_ack && !stall && !halt;
         ST_HOLD:  upd = !stall && !halt;
         default:  upd = 1'b0;
      endcase

      pc_enable = reset && upd;
      pc_next   = (state_q == ST_BOOT) ? RESET_VECTOR : pc_sel_c;

      // Redirects arriving while the PC cannot advance are held; exceptions always win the slot.
      if (upd) begin
         pend_valid_d = 1'b0;
      end else if (state_q == ST_FETCH || state_q == ST_HOLD) begin
         if (exception) begin
            pend_valid_d  = 1'b1;
            pend_target_d = EXC_VECTOR;
         end else if (!pend_valid_q) begin
            if (jump) begin
               pend_valid_d  = 1'b1;
               pend_target_d = jump_target;
            end else if (branch_taken) begin
               pend_valid_d  = 1'b1;
               pend_target_d = branch_target;
            end
         end
      end
   end

   assign fetch_req        = fetch_req_q;
   assign redirect_pending = pend_valid_q;
   assign state            = 2'(state_q);

endmodule
